// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default parameter values for the run_ctrl test sequencer.
package run_ctrl_pkg;

    localparam int unsigned DEF_OBS_W         = 8;
    localparam int unsigned DEF_CNT_W         = 32;
    localparam int unsigned DEF_PRE_CYC       = 12;
    localparam int unsigned DEF_REPORT_PERIOD = 10;
    localparam int unsigned DEF_MAX_CYC       = 2000;
    localparam int unsigned DEF_STABLE_CYC    = 4;
    localparam logic        DEF_DUT_RST_ACT   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

endpackage

// File: rtl/run_ctrl_tick.sv
// Modulo-PERIOD strobe: stb is high in the cycle after each enabled cycle taken at phase 0,
// so driving en with "next cycle is counted" yields a strobe aligned to counted cycles.
module run_ctrl_tick
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_REPORT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic stb
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
            stb   <= 1'b0;
        end else begin
            stb <= en && (phase == '0);
            if (en) begin
                phase <= (phase == PW'(PERIOD - 1)) ? '0 : phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds a DUT in reset, runs it for a cycle budget and latches a pass/fail verdict.
// Optional obs change tracing is built only when RUN_CTRL_OBS_TRACE_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned OBS_W         = DEF_OBS_W,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned PRE_CYC       = DEF_PRE_CYC,
    parameter int unsigned REPORT_PERIOD = DEF_REPORT_PERIOD,
    parameter int unsigned MAX_CYC       = DEF_MAX_CYC,
    parameter int unsigned STABLE_CYC    = DEF_STABLE_CYC,
    parameter logic        DUT_RST_ACT   = DEF_DUT_RST_ACT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OBS_W-1:0] obs,
    input  logic [OBS_W-1:0] pass_val,
    output logic             dut_rst,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             report_stb,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] obs_chg_cnt
);

    localparam int unsigned PRE_W = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
    localparam int unsigned STB_W = $clog2(STABLE_CYC + 1);

    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre_cnt, pre_nxt;
    logic [STB_W-1:0] stab_cnt, stab_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pass_nxt, fail_nxt, dut_rst_nxt, busy_nxt;
    logic             start_ok;

    // State register plus registered copies of every next-state output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            stab_cnt  <= '0;
            cycle_cnt <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            dut_rst   <= DUT_RST_ACT;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pre_cnt   <= pre_nxt;
            stab_cnt  <= stab_nxt;
            cycle_cnt <= cnt_nxt;
            pass      <= pass_nxt;
            fail      <= fail_nxt;
            dut_rst   <= dut_rst_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pre_nxt     = pre_cnt;
        stab_nxt    = stab_cnt;
        cnt_nxt     = cycle_cnt;
        pass_nxt    = pass;
        fail_nxt    = fail;
        start_ok    = 1'b0;
        dut_rst_nxt = DUT_RST_ACT;
        busy_nxt    = 1'b0;

        case (state)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_nxt = ST_RESET;
                    start_ok  = 1'b1;
                    pre_nxt   = '0;
                    stab_nxt  = '0;
                    cnt_nxt   = '0;
                    pass_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
                end
            end
            ST_RESET: begin
                if (pre_cnt == PRE_W'(PRE_CYC - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    pre_nxt = pre_cnt + PRE_W'(1);
                end
            end
            ST_RUN: begin
                if (obs == pass_val) begin
                    stab_nxt = (stab_cnt == '1) ? stab_cnt : stab_cnt + STB_W'(1);
                end else begin
                    stab_nxt = '0;
                end
                // Pass takes priority over a coincident timeout; the final cycle count is kept.
                if (stab_nxt >= STB_W'(STABLE_CYC)) begin
                    state_nxt = ST_PASS;
                    pass_nxt  = 1'b1;
                end else if (cycle_cnt == CNT_W'(MAX_CYC - 1)) begin
                    state_nxt = ST_FAIL;
                    fail_nxt  = 1'b1;
                end else begin
                    cnt_nxt = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // IDLE is only reachable through rst, where the DUT is held in reset.
        dut_rst_nxt = (state_nxt inside {ST_IDLE, ST_RESET}) ? DUT_RST_ACT : ~DUT_RST_ACT;
        busy_nxt    = (state_nxt inside {ST_RESET, ST_RUN});
    end

    run_ctrl_tick #(
        .PERIOD (REPORT_PERIOD)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (state_nxt == ST_RUN),
        .stb (report_stb)
    );

`ifdef RUN_CTRL_OBS_TRACE_EN
    logic [OBS_W-1:0] obs_prev;
    logic [CNT_W-1:0] chg_cnt;

    // obs_prev is refreshed through RESET so the first RUN cycle compares against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            obs_prev <= '0;
            chg_cnt  <= '0;
        end else begin
            if (start_ok) begin
                chg_cnt <= '0;
            end else if (state == ST_RUN && obs != obs_prev && chg_cnt != '1) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
            if (state == ST_RESET || state == ST_RUN) begin
                obs_prev <= obs;
            end
        end
    end

    assign obs_chg_cnt = chg_cnt;
`else
    assign obs_chg_cnt = '0;
`endif

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter: OBS_W, 8, width of the observed DUT status bus.
REQ-002 Parameter: CNT_W, 32, width of the run cycle counter.
REQ-003 Parameter: PRE_CYC, 12, DUT reset hold length in cycles (≥1).
REQ-004 Parameter: REPORT_PERIOD, 10, report strobe period in RUN cycles (≥1).
REQ-005 Parameter: MAX_CYC, 2000, RUN cycle budget before timeout (≥1, < 2^CNT_W).
REQ-006 Parameter: STABLE_CYC, 4, consecutive matching cycles required for pass (≥1).
REQ-007 Parameter: DUT_RST_ACT, 1, active level of dut_rst.
REQ-008 Ports: clk  in  1  single clock, all logic on rising edge; reset is synchronous and active-high.
REQ-009 Ports: rst  in  1  synchronous active-high reset.
REQ-010 Ports: start  in  1  run request, sampled in IDLE/PASS/FAIL.
REQ-011 Ports: obs  in  OBS_W  observed DUT status (e.g. led bus).
REQ-012 Ports: pass_val  in  OBS_W  obs value signalling success.
REQ-013 Ports: dut_rst  out  1  reset driven to the DUT.
REQ-014 Ports: busy  out  1  high in RESET or RUN.
REQ-015 Ports: cycle_cnt  out  CNT_W  RUN cycles elapsed.
REQ-016 Ports: report_stb  out  1  one-cycle periodic progress pulse.
REQ-017 Ports: pass / fail  out  1 each  sticky verdict flags.
REQ-018 Ports: obs_chg_cnt  out  CNT_W  count of obs changes during RUN.

Function
REQ-019 FSM states IDLE, RESET, RUN, PASS, FAIL SHALL be the only states; an illegal encoding SHALL go to IDLE.
REQ-020 IDLE/PASS/FAIL with start=1 SHALL go to RESET next cycle, clearing cycle_cnt, obs_chg_cnt, pass, fail; start SHALL be ignored in RESET and RUN.
REQ-021 RESET SHALL assert dut_rst=DUT_RST_ACT for exactly PRE_CYC cycles, then enter RUN; dut_rst SHALL be inactive in every other state.
REQ-022 cycle_cnt SHALL read 0 in the first RUN cycle and increment by 1 every RUN cycle; it SHALL hold its value in PASS/FAIL.
REQ-023 report_stb SHALL be high in exactly those RUN cycles where cycle_cnt mod REPORT_PERIOD == 0 (including cycle 0), implemented with a modulo counter, not a divider.
REQ-024 A stable counter SHALL count consecutive RUN cycles with obs==pass_val and reset to 0 on any mismatch; when it reaches STABLE_CYC the next state SHALL be PASS with pass=1.
REQ-025 In the RUN cycle with cycle_cnt==MAX_CYC-1 without a pass condition, the next state SHALL be FAIL with fail=1.
REQ-026 If pass and timeout conditions coincide in the same cycle, PASS SHALL win.
REQ-027 pass and fail SHALL never both be 1; they SHALL hold until rst or an accepted start.
REQ-028 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-029 rst=1 SHALL force, on the next edge: state IDLE, dut_rst=DUT_RST_ACT, busy=0, cycle_cnt=0, report_stb=0, pass=0, fail=0, obs_chg_cnt=0, internal counters 0; this SHALL override any in-progress RESET/RUN.
REQ-030 In IDLE after rst, dut_rst SHALL remain at DUT_RST_ACT until a run completes its RESET phase.

Configuration
REQ-031 Macro RUN_CTRL_OBS_TRACE_EN: when defined, obs_chg_cnt SHALL increment in each RUN cycle where obs differs from its value in the previous cycle (first RUN cycle compares with the value sampled in the last RESET cycle); when undefined, obs_chg_cnt SHALL be constant 0 and its registers SHALL not be built.

Structure
REQ-032 State encoding typedef and default parameter constants SHALL live in shared package run_ctrl_pkg.
REQ-033 Periodic strobe generation SHALL be sub-module run_ctrl_tick (modulo counter with enable and clear).

Verification
REQ-034 rst 3 cycles, start pulse at cycle 0 -> dut_rst active cycles 1-12, RUN from cycle 13, cycle_cnt=0 there.
REQ-035 Defaults, obs=0x00, pass_val=0xFF -> report_stb at cycle_cnt 0,10,20,..; fail=1 after cycle_cnt=1999; cycle_cnt holds 1999.
REQ-036 obs=0xFF from cycle_cnt 50, with one 0x00 glitch at 52 -> pass=1 only after cycle_cnt 56 (4 matches at 53-56), fail=0.
REQ-037 MAX_CYC=20, obs reaching 4th consecutive match exactly at cycle_cnt 19 -> PASS, fail=0.
REQ-038 rst asserted mid-RUN at cycle_cnt 100 -> next cycle all outputs at reset values; start during RUN -> ignored.
REQ-039 With RUN_CTRL_OBS_TRACE_EN, obs toggling 0x01/0x02 for 6 RUN cycles -> obs_chg_cnt=6; without macro -> 0.
